rain_drop_counter: RTL and testbench

Rain-sensor front end for the windshield-wiper controller. It synchronises and debounces the raw drop-detector pulse, counts accepted drops over a fixed window of clock cycles, and presents the saturated 6-bit count as `chuva` with a one-cycle valid strobe. It sits directly upstream of the wiper state machine and replaces the switch-driven `chuva` on the board.

---
 rtl/rain_pkg.sv | 17 +
 rtl/rain_drop_counter_if.sv | 23 ++
 rtl/drop_debouncer.sv | 101 ++++++++++
 rtl/rain_drop_counter.sv | 72 +++++++
 tb/tb_rain_drop_counter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rain_pkg.sv
// Shared constants and types for the rain-sensor front end.
// Default geometry and the debouncer state encoding live here.
package rain_pkg;

  localparam int NBITS_CHUVA  = 6;
  localparam int CHUVA_MAX    = 2**NBITS_CHUVA - 1;
  localparam int WINDOW_DEF   = 8;
  localparam int DEBOUNCE_DEF = 2;

  typedef enum logic [1:0] {
    DB_LOW,
    DB_RISE,
    DB_HIGH,
    DB_FALL
  } db_state_t;

endpackage

// File: rtl/rain_drop_counter_if.sv
// Sensor input and count outputs of the rain front end, bundled for the wiper controller.
// The master side drives the raw sensor and consumes the counts.
interface rain_drop_counter_if #(
  parameter int NBITS_CHUVA = rain_pkg::NBITS_CHUVA
);

  logic                   drop_in;
  logic [NBITS_CHUVA-1:0] chuva;
  logic                   chuva_valid;
  logic [NBITS_CHUVA-1:0] chuva_live;
  logic                   overflow;

  modport master (
    output drop_in,
    input  chuva, chuva_valid, chuva_live, overflow
  );

  modport slave (
    input  drop_in,
    output chuva, chuva_valid, chuva_live, overflow
  );

endinterface

// File: rtl/drop_debouncer.sv
// Two-flop synchroniser plus a four-state debouncer for the raw drop detector.
// o_drop_evt pulses for one cycle when a debounced rising edge is accepted.
module drop_debouncer
  import rain_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk_2,
  input  logic reset_n,
  input  logic i_drop_in,
  output logic o_drop_evt
);

  localparam int             CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    r_sync;
  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [CW-1:0] r_deb_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_drop_s;
  logic          w_evt;

  assign w_drop_s = r_sync[1];

  // The transition fires on the sample that would bring deb_cnt up to DEBOUNCE,
  // so the counter is cleared instead of ever holding DEBOUNCE itself.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_deb_cnt;
    w_evt       = 1'b0;
    case (r_state)
      DB_LOW: begin
        if (w_drop_s) begin
          if (DEBOUNCE == 1) begin
            w_state_nxt = DB_HIGH;
            w_evt       = 1'b1;
          end else begin
            w_state_nxt = DB_RISE;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      DB_RISE: begin
        if (!w_drop_s) begin
          w_state_nxt = DB_LOW;
          w_cnt_nxt   = '0;
        end else if (r_deb_cnt == CNT_LAST) begin
          w_state_nxt = DB_HIGH;
          w_cnt_nxt   = '0;
          w_evt       = 1'b1;
        end else begin
          w_cnt_nxt = r_deb_cnt + 1'b1;
        end
      end
      DB_HIGH: begin
        if (!w_drop_s) begin
          if (DEBOUNCE == 1) begin
            w_state_nxt = DB_LOW;
          end else begin
            w_state_nxt = DB_FALL;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      DB_FALL: begin
        if (w_drop_s) begin
          w_state_nxt = DB_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_deb_cnt == CNT_LAST) begin
          w_state_nxt = DB_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_deb_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = DB_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_state   <= DB_LOW;
      r_deb_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; the sync chain depends on it.
      r_sync    <= {r_sync[0], i_drop_in};
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_cnt_nxt;
    end
  end

  assign o_drop_evt = w_evt;

endmodule

// File: rtl/rain_drop_counter.sv
// Rain-sensor front end: debounced drops counted over a fixed window of clk_2 cycles,
// published as a saturated count with a one-cycle valid strobe and an overflow flag.
module rain_drop_counter #(
  parameter int WINDOW      = rain_pkg::WINDOW_DEF,
  parameter int DEBOUNCE    = rain_pkg::DEBOUNCE_DEF,
  parameter int NBITS_CHUVA = rain_pkg::NBITS_CHUVA
) (
  input  logic                clk_2,
  input  logic                reset_n,
  rain_drop_counter_if.slave  bus
);

  localparam int                     WW       = $clog2(WINDOW);
  localparam logic [WW-1:0]          WIN_LAST = WW'(WINDOW - 1);
  localparam logic [NBITS_CHUVA-1:0] CNT_MAX  = '1;

  logic                   w_drop_evt;
  logic [WW-1:0]          r_win_cnt;
  logic [NBITS_CHUVA-1:0] r_live;
  logic [NBITS_CHUVA-1:0] r_chuva;
  logic                   r_valid;
  logic                   r_overflow;
  logic                   r_ovf_pend;
  logic [NBITS_CHUVA:0]   w_sum;
  logic [NBITS_CHUVA-1:0] w_sat;
  logic                   w_win_end;

  drop_debouncer #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debouncer (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .i_drop_in  (bus.drop_in),
    .o_drop_evt (w_drop_evt)
  );

  // One extra bit catches the step past the maximum; the live count itself never exceeds it.
  assign w_sum     = {1'b0, r_live} + {{NBITS_CHUVA{1'b0}}, w_drop_evt};
  assign w_sat     = w_sum[NBITS_CHUVA] ? CNT_MAX : w_sum[NBITS_CHUVA-1:0];
  assign w_win_end = (r_win_cnt == WIN_LAST);

  // r_ovf_pend remembers a clipped drop anywhere in the window, since r_live hides it once pinned.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_win_cnt  <= '0;
      r_live     <= '0;
      r_chuva    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_ovf_pend <= 1'b0;
    end else begin
      r_valid <= w_win_end;
      if (w_win_end) begin
        r_win_cnt  <= '0;
        r_chuva    <= w_sat;
        r_overflow <= r_ovf_pend | w_sum[NBITS_CHUVA];
        r_ovf_pend <= 1'b0;
        r_live     <= '0;
      end else begin
        r_win_cnt  <= r_win_cnt + 1'b1;
        r_live     <= w_sat;
        r_ovf_pend <= r_ovf_pend | w_sum[NBITS_CHUVA];
      end
    end
  end

  assign bus.chuva       = r_chuva;
  assign bus.chuva_valid = r_valid;
  assign bus.chuva_live  = r_live;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_rain_drop_counter.sv
// Bench for rain_drop_counter: a WINDOW=8/DEBOUNCE=2 instance and a WINDOW=256/DEBOUNCE=1 instance
// checked against a drop-counting reference model, a directed vector table and corner sequences.
module tb_rain_drop_counter;
  import rain_pkg::*;

  localparam int WA = 8;
  localparam int DA = 2;
  localparam int WB = 256;
  localparam int DB = 1;

  logic clk_2 = 1'b0;
  logic reset_n;

  always #5 clk_2 = ~clk_2;

  rain_drop_counter_if #(.NBITS_CHUVA(NBITS_CHUVA)) if_a ();
  rain_drop_counter_if #(.NBITS_CHUVA(NBITS_CHUVA)) if_b ();

  rain_drop_counter #(.WINDOW(WA), .DEBOUNCE(DA), .NBITS_CHUVA(NBITS_CHUVA)) dut_a (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  rain_drop_counter #(.WINDOW(WB), .DEBOUNCE(DB), .NBITS_CHUVA(NBITS_CHUVA)) dut_b (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  // Reference model: accepted level flips after DEBOUNCE consecutive opposite samples,
  // the sample seen at edge e is drop_in from edge e-2, and each window tallies rising acceptances.
  typedef struct {
    bit p0;
    bit p1;
    bit lvl;
    int run;
    int edge_no;
    int win_true;
    int live;
    int chuva;
    int valid;
    int ovf;
  } model_t;

  typedef struct {
    bit din;
    int live;
    int valid;
    int chuva;
    int ovf;
  } vec_t;

  int     n_vec = 0;
  int     n_bad = 0;
  model_t ma;
  model_t mb;
  vec_t   tbl[40];
  int     ones[10] = '{6, 7, 8, 12, 13, 14, 18, 29, 30, 31};

  function automatic model_t model_step(model_t m, int win, int deb, bit din);
    bit x;
    int evt;
    x    = m.p1;
    m.p1 = m.p0;
    m.p0 = din;
    evt  = 0;
    if (x != m.lvl) begin
      m.run++;
      if (m.run == deb) begin
        m.lvl = x;
        m.run = 0;
        evt   = x ? 1 : 0;
      end
    end else begin
      m.run = 0;
    end
    m.edge_no++;
    m.win_true += evt;
    m.valid = (m.edge_no % win == 0) ? 1 : 0;
    if (m.valid == 1) begin
      m.chuva    = (m.win_true > CHUVA_MAX) ? CHUVA_MAX : m.win_true;
      m.ovf      = (m.win_true > CHUVA_MAX) ? 1 : 0;
      m.win_true = 0;
      m.live     = 0;
    end else begin
      m.live = (m.win_true > CHUVA_MAX) ? CHUVA_MAX : m.win_true;
    end
    return m;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m = '{default: 0};
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int live, input int valid, input int chuva,
                            input int ovf, input int e_live, input int e_valid, input int e_chuva,
                            input int e_ovf);
    check({tag, " live"},  live,  e_live);
    check({tag, " valid"}, valid, e_valid);
    check({tag, " chuva"}, chuva, e_chuva);
    check({tag, " ovf"},   ovf,   e_ovf);
  endtask

  task automatic check_zero(input string tag);
    check_outs({tag, " A"}, int'(if_a.chuva_live), int'(if_a.chuva_valid), int'(if_a.chuva),
               int'(if_a.overflow), 0, 0, 0, 0);
    check_outs({tag, " B"}, int'(if_b.chuva_live), int'(if_b.chuva_valid), int'(if_b.chuva),
               int'(if_b.overflow), 0, 0, 0, 0);
  endtask

  // One clock: drive both sensors, advance both models, compare after the edge settles.
  task automatic step(input bit da, input bit db);
    if_a.drop_in = da;
    if_b.drop_in = db;
    @(posedge clk_2);
    ma = model_step(ma, WA, DA, da);
    mb = model_step(mb, WB, DB, db);
    #1;
    check_outs($sformatf("model A e%0d", ma.edge_no), int'(if_a.chuva_live), int'(if_a.chuva_valid),
               int'(if_a.chuva), int'(if_a.overflow), ma.live, ma.valid, ma.chuva, ma.ovf);
    check_outs($sformatf("model B e%0d", mb.edge_no), int'(if_b.chuva_live), int'(if_b.chuva_valid),
               int'(if_b.chuva), int'(if_b.overflow), mb.live, mb.valid, mb.chuva, mb.ovf);
  endtask

  task automatic apply_reset(input int cycles);
    #2;
    reset_n      = 1'b0;
    if_a.drop_in = 1'b0;
    if_b.drop_in = 1'b0;
    #1;
    check_zero("rst assert");
    ma = model_reset();
    mb = model_reset();
    repeat (cycles) begin
      @(posedge clk_2);
      #1;
      check_zero("rst hold");
    end
    @(negedge clk_2);
    reset_n = 1'b1;
  endtask

  initial begin
    bit a_lvl;
    int a_left;

    reset_n      = 1'b0;
    if_a.drop_in = 1'b0;
    if_b.drop_in = 1'b0;

    // Directed table for the WINDOW=8/DEBOUNCE=2 instance, edges 1..40 after release:
    // idle window, two clean pulses, a one-cycle glitch, then a drop landing on the closing edge.
    for (int i = 0; i < 40; i++) tbl[i] = '{din: 1'b0, live: 0, valid: 0, chuva: 0, ovf: 0};
    foreach (ones[k]) tbl[ones[k]-1].din = 1'b1;
    for (int e = 9; e <= 14; e++) tbl[e-1].live = 1;
    tbl[14].live = 2;
    for (int e = 8; e <= 40; e += 8) tbl[e-1].valid = 1;
    for (int e = 16; e <= 23; e++) tbl[e-1].chuva = 2;
    for (int e = 32; e <= 39; e++) tbl[e-1].chuva = 1;

    apply_reset(3);
    for (int e = 1; e <= 40; e++) begin
      step(tbl[e-1].din, 1'b0);
      check_outs($sformatf("tbl e%0d", e), int'(if_a.chuva_live), int'(if_a.chuva_valid),
                 int'(if_a.chuva), int'(if_a.overflow),
                 tbl[e-1].live, tbl[e-1].valid, tbl[e-1].chuva, tbl[e-1].ovf);
    end

    // Saturation on the WINDOW=256/DEBOUNCE=1 instance: 70 drops in one window.
    apply_reset(2);
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    for (int e = 141; e <= 2 * WB; e++) begin
      step(1'b0, 1'b0);
      if (e == 200) check("sat live held", int'(if_b.chuva_live), CHUVA_MAX);
      if (e == WB) begin
        check("sat valid", int'(if_b.chuva_valid), 1);
        check("sat chuva", int'(if_b.chuva), CHUVA_MAX);
        check("sat ovf", int'(if_b.overflow), 1);
      end
      if (e == 2 * WB) begin
        check("empty chuva", int'(if_b.chuva), 0);
        check("empty ovf", int'(if_b.overflow), 0);
      end
    end

    // Reset mid-window with two drops accumulated on instance A.
    apply_reset(1);
    for (int e = 1; e <= 14; e++) step((e inside {7, 8, 11, 12}) ? 1'b1 : 1'b0, 1'b0);
    check("pre-rst live", int'(if_a.chuva_live), 2);
    apply_reset(2);
    for (int e = 1; e <= WA; e++) begin
      step((e <= 3) ? 1'b1 : 1'b0, 1'b0);
      if (e == 4) check("post-rst live", int'(if_a.chuva_live), 1);
      if (e == WA) begin
        check("post-rst valid", int'(if_a.chuva_valid), 1);
        check("post-rst chuva", int'(if_a.chuva), 1);
      end
    end

    // Randomised runs: A sees levels of length 1..4 (glitches and real drops), B sees random bits.
    apply_reset(1);
    a_lvl  = 1'b0;
    a_left = 0;
    for (int i = 0; i < 900; i++) begin
      if (i == 450) apply_reset(2);
      if (a_left == 0) begin
        a_lvl  = ~a_lvl;
        a_left = int'($urandom_range(1, 4));
      end
      a_left--;
      step(a_lvl, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
